draw_bg_scroll: RTL and testbench

Parametrised background renderer; the next generation of the fixed-colour background stage. Fetches pixels from an external synchronous background ROM, upscales the image by a power-of-two factor, and scrolls it with per-frame wrap-around offsets. It also offers solid-fill and checkerboard debug modes. It sits first in the VGA drawing chain, between the timing generator and the sprite/overlay stages, and delays all timing signals to stay aligned with its pixel data.

---
 rtl/vga_pkg.sv | 30 +++
 rtl/vga_if.sv | 18 +
 rtl/vga_delay.sv | 31 +++
 rtl/draw_bg_scroll.sv | 154 +++++++++++++++
 tb/tb_draw_bg_scroll.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared VGA drawing-chain definitions.
//   HOR_PIXELS / VER_PIXELS : visible resolution of the timing generator
//   CNT_W                   : width of the hcount / vcount counters
//   bg_mode_t               : background render mode selector
//   bg_side_t               : per-pixel side-band bits carried alongside the ROM fetch
package vga_pkg;

  localparam int HOR_PIXELS = 800;
  localparam int VER_PIXELS = 600;
  localparam int CNT_W      = 11;
  localparam int RGB_W      = 12;

  typedef enum logic [1:0] {
    BG_ROM   = 2'd0,
    BG_FILL  = 2'd1,
    BG_CHECK = 2'd2,
    BG_RSVD  = 2'd3
  } bg_mode_t;

  // valid is cleared by reset so a refilling pipeline emits all-zero pixels
  // instead of border colour.
  typedef struct packed {
    logic             valid;
    logic             active;
    logic             check;
    bg_mode_t         mode;
    logic [RGB_W-1:0] fill;
  } bg_side_t;

endpackage

// File: rtl/vga_if.sv
// VGA timing bundle passed between drawing stages.
//   vga_in  : timing consumed by a stage (counters, syncs, blanks)
//   vga_out : timing produced by a stage plus its rgb pixel
interface vga_if;
  import vga_pkg::*;

  logic [CNT_W-1:0] vcount;
  logic [CNT_W-1:0] hcount;
  logic             vsync;
  logic             hsync;
  logic             vblnk;
  logic             hblnk;
  logic [RGB_W-1:0] rgb;

  modport vga_in  (input  vcount, hcount, vsync, hsync, vblnk, hblnk);
  modport vga_out (output vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);

endinterface

// File: rtl/vga_delay.sv
// Fixed-depth shift register for timing / side-band bits.
//   clk    : pixel clock
//   rst_n  : synchronous active-low reset, clears every stage
//   i_data : word entering the pipe
//   o_data : i_data delayed by DEPTH cycles (DEPTH >= 1)
module vga_delay #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  logic [DEPTH-1:0][WIDTH-1:0] r_pipe;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pipe <= '0;
    end else begin
      r_pipe[0] <= i_data;
      for (int i = 1; i < DEPTH; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign o_data = r_pipe[DEPTH-1];

endmodule

// File: rtl/draw_bg_scroll.sv
// Scrolling, upscaled background renderer; first stage of the drawing chain.
//   clk, rst_n            : pixel clock, synchronous active-low reset
//   mode, fill_rgb        : render mode and solid-fill colour
//   scroll_en/dx/dy, home : per-frame offset control, sampled at the frame tick
//   rom_addr, rom_data    : external synchronous ROM ({src_y, src_x} -> pixel)
//   vga_in                : timing from the generator
//   vga_out               : timing delayed by ROM_LATENCY+2 cycles plus rgb
module draw_bg_scroll
  import vga_pkg::*;
#(
  parameter int          BG_W        = 128,
  parameter int          BG_H        = 128,
  parameter int          SCALE_LOG2  = 3,
  parameter int          ROM_LATENCY = 1,
  parameter logic [11:0] BORDER_RGB  = 12'h888,
  parameter int          ADDR_W      = $clog2(BG_W) + $clog2(BG_H)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  bg_mode_t          mode,
  input  logic [11:0]       fill_rgb,
  input  logic              scroll_en,
  input  logic [3:0]        scroll_dx,
  input  logic [3:0]        scroll_dy,
  input  logic              home,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [11:0]       rom_data,
  vga_if.vga_in             vga_in,
  vga_if.vga_out            vga_out
);

  localparam int XW  = $clog2(BG_W);
  localparam int YW  = $clog2(BG_H);
  localparam int LAT = ROM_LATENCY + 2;
  localparam int TW  = 2 * CNT_W + 4;

  logic              r_vblnk_prev;
  logic              r_primed;
  logic [XW-1:0]     r_off_x;
  logic [YW-1:0]     r_off_y;
  logic [ADDR_W-1:0] r_rom_addr;
  logic [11:0]       r_rgb;

  logic              w_tick;
  logic [XW-1:0]     w_src_x;
  logic [YW-1:0]     w_src_y;
  bg_side_t          w_side;
  bg_side_t          w_side_d;
  logic [TW-1:0]     w_tim_in;
  logic [TW-1:0]     w_tim_d;
  logic [11:0]       w_rgb;

  // r_primed blocks a tick on the first sample after reset, when the vblnk
  // history does not yet hold a real value.
  assign w_tick = r_primed & vga_in.vblnk & ~r_vblnk_prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vblnk_prev <= 1'b0;
      r_primed     <= 1'b0;
      r_off_x      <= '0;
      r_off_y      <= '0;
    end else begin
      r_vblnk_prev <= vga_in.vblnk;
      r_primed     <= 1'b1;
      if (w_tick) begin
        if (home) begin
          r_off_x <= '0;
          r_off_y <= '0;
        end else if (scroll_en) begin
          // Sign-extend the 4-bit step; truncation to the index width wraps.
          r_off_x <= r_off_x + XW'($signed(scroll_dx));
          r_off_y <= r_off_y + YW'($signed(scroll_dy));
        end
      end
    end
  end

  // Truncating the scaled counter before the add is the modulo-image wrap.
  assign w_src_x = XW'(vga_in.hcount >> SCALE_LOG2) + r_off_x;
  assign w_src_y = YW'(vga_in.vcount >> SCALE_LOG2) + r_off_y;

  always_comb begin
    w_side        = '0;
    w_side.valid  = 1'b1;
    w_side.active = ~vga_in.hblnk & ~vga_in.vblnk;
    w_side.check  = w_src_x[3] ^ w_src_y[3];
    w_side.mode   = mode;
    w_side.fill   = fill_rgb;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rom_addr <= '0;
    end else begin
      r_rom_addr <= {w_src_y, w_src_x};
    end
  end

  assign rom_addr = r_rom_addr;

  // Side-band leaves its last stage in the same cycle rom_data is valid.
  vga_delay #(
    .DEPTH (ROM_LATENCY + 1),
    .WIDTH ($bits(bg_side_t))
  ) u_side_dly (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_data (w_side),
    .o_data (w_side_d)
  );

  assign w_tim_in = {vga_in.vcount, vga_in.hcount, vga_in.vsync,
                     vga_in.hsync, vga_in.vblnk, vga_in.hblnk};

  vga_delay #(
    .DEPTH (LAT),
    .WIDTH (TW)
  ) u_tim_dly (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_data (w_tim_in),
    .o_data (w_tim_d)
  );

  always_comb begin
    w_rgb = 12'h000;
    if (w_side_d.valid) begin
      if (!w_side_d.active) begin
        w_rgb = BORDER_RGB;
      end else begin
        case (w_side_d.mode)
          BG_ROM:   w_rgb = rom_data;
          BG_FILL:  w_rgb = w_side_d.fill;
          BG_CHECK: w_rgb = w_side_d.check ? 12'hFFF : 12'h000;
          default:  w_rgb = BORDER_RGB;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rgb <= '0;
    end else begin
      r_rgb <= w_rgb;
    end
  end

  assign {vga_out.vcount, vga_out.hcount, vga_out.vsync,
          vga_out.hsync, vga_out.vblnk, vga_out.hblnk} = w_tim_d;
  assign vga_out.rgb = r_rgb;

endmodule

// File: tb/tb_draw_bg_scroll.sv
// Testbench for draw_bg_scroll: drives compact synthetic frames, models the
// renderer arithmetically and compares timing, rgb and rom_addr every cycle.
module tb_draw_bg_scroll;
  import vga_pkg::*;

  localparam int BG_W = 128;
  localparam int BG_H = 128;
  localparam int LAT  = 1;
  localparam int L    = LAT + 2;
  localparam int BORDER = 'h888;

  logic        clk = 1'b0;
  logic        rst_n;
  bg_mode_t    mode;
  logic [11:0] fill_rgb;
  logic        scroll_en;
  logic [3:0]  scroll_dx;
  logic [3:0]  scroll_dy;
  logic        home;
  logic [13:0] rom_addr;
  logic [11:0] rom_data;

  vga_if u_vin ();
  vga_if u_vout ();

  always #5 clk = ~clk;

  draw_bg_scroll #(
    .BG_W        (BG_W),
    .BG_H        (BG_H),
    .SCALE_LOG2  (3),
    .ROM_LATENCY (LAT),
    .BORDER_RGB  (12'h888)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .fill_rgb  (fill_rgb),
    .scroll_en (scroll_en),
    .scroll_dx (scroll_dx),
    .scroll_dy (scroll_dy),
    .home      (home),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .vga_in    (u_vin),
    .vga_out   (u_vout)
  );

  // ROM contents: word a = low 12 bits of a XOR 0xA5C
  function automatic int rom_word(input int a);
    return (a & 'hFFF) ^ 'hA5C;
  endfunction

  always @(posedge clk) rom_data <= 12'(rom_word(int'(rom_addr)));

  typedef struct {
    bit rst;
    int v, h;
    bit vs, hs, vb, hb;
    int mode, fill, ox, oy, tag;
  } smp_t;

  smp_t hist [8];
  int   k = 0;
  int   m_ox = 0, m_oy = 0;
  bit   prev_ok = 0, prev_vb = 0;
  int   tag = 0;
  int   vec = 0, errs = 0;

  function automatic int sext4(input logic [3:0] d);
    return d[3] ? int'(d) - 16 : int'(d);
  endfunction

  function automatic int wrap(input int a, input int n);
    return ((a % n) + n) % n;
  endfunction

  function automatic int src_x(input smp_t s);
    return wrap(s.h / 8 + s.ox, BG_W);
  endfunction

  function automatic int src_y(input smp_t s);
    return wrap(s.v / 8 + s.oy, BG_H);
  endfunction

  function automatic int pix(input smp_t s);
    int sx, sy;
    if (s.hb || s.vb) return BORDER;
    sx = src_x(s);
    sy = src_y(s);
    case (s.mode)
      0: return rom_word(sy * BG_W + sx);
      1: return s.fill;
      2: return (((sx / 8) % 2) != ((sy / 8) % 2)) ? 'hFFF : 'h000;
      default: return BORDER;
    endcase
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    vec++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s t=%0t: got 0x%0h, want 0x%0h", nm, $time, act, exp);
    end
  endtask

  // Behavioural model: record every sampled input and step the offsets.
  initial begin : model
    smp_t s;
    for (int i = 0; i < 8; i++) hist[i].rst = 1;
    forever begin
      @(posedge clk);
      s.rst  = !rst_n;
      s.v    = int'(u_vin.vcount);
      s.h    = int'(u_vin.hcount);
      s.vs   = u_vin.vsync;
      s.hs   = u_vin.hsync;
      s.vb   = u_vin.vblnk;
      s.hb   = u_vin.hblnk;
      s.mode = int'(mode);
      s.fill = int'(fill_rgb);
      s.ox   = m_ox;
      s.oy   = m_oy;
      s.tag  = tag;
      if (s.rst) begin
        m_ox = 0;
        m_oy = 0;
      end else if (prev_ok && !prev_vb && s.vb) begin
        if (home) begin
          m_ox = 0;
          m_oy = 0;
        end else if (scroll_en) begin
          m_ox = wrap(m_ox + sext4(scroll_dx), BG_W);
          m_oy = wrap(m_oy + sext4(scroll_dy), BG_H);
        end
      end
      prev_ok = !s.rst;
      prev_vb = s.vb;
      hist[k % 8] = s;
      k++;
    end
  end

  // Compare process, sampled on the falling edge.
  initial begin : compare
    smp_t s, a;
    bit   z;
    int   last;
    logic [25:0] et, at;
    forever begin
      @(negedge clk);
      last = k - 1;
      if (last >= 0) begin
        z = 0;
        for (int i = last - (L - 1); i <= last; i++) begin
          if (i < 0) z = 1;
          else if (hist[i % 8].rst) z = 1;
        end
        at = {u_vout.vcount, u_vout.hcount, u_vout.vsync, u_vout.hsync,
              u_vout.vblnk, u_vout.hblnk};
        if (z) begin
          check("timing", int'(at), 0);
          check("rgb", int'(u_vout.rgb), 0);
          if (hist[last % 8].tag == 7)
            check("rst_zero", int'({u_vout.rgb, u_vout.hcount}), 0);
        end else begin
          s  = hist[(last - (L - 1)) % 8];
          et = {11'(s.v), 11'(s.h), s.vs, s.hs, s.vb, s.hb};
          check("timing", int'(at), int'(et));
          check("rgb", int'(u_vout.rgb), pix(s));
          if (s.tag == 1 && s.v == 0 && s.h < 8)  check("word0", int'(u_vout.rgb), 'hA5C);
          if (s.tag == 1 && s.v == 0 && s.h == 8) check("word1", int'(u_vout.rgb), 'hA5D);
          if (s.tag == 2 && s.v == 0 && s.h == 0) check("wrap128", int'(u_vout.rgb), 'hA5C);
          if (s.tag == 4 && s.v == 0 && s.h == 99)  check("pre_switch", int'(u_vout.rgb), 'hA50);
          if (s.tag == 4 && s.v == 0 && s.h == 100) check("post_switch", int'(u_vout.rgb), 'hFFF);
          if (s.tag == 4 && s.v == 1 && s.h == 64)  check("chk_8_0", int'(u_vout.rgb), 'hFFF);
          if (s.tag == 4 && s.v == 64 && s.h == 64) check("chk_8_8", int'(u_vout.rgb), 'h000);
          if (s.tag == 4 && s.v == 0 && s.h == 112) check("border", int'(u_vout.rgb), 'h888);
        end
        a = hist[last % 8];
        check("rom_addr", int'(rom_addr), a.rst ? 0 : src_y(a) * BG_W + src_x(a));
        if (!a.rst && a.tag == 3 && a.v == 0 && a.h == 0) check("addr_dy", int'(rom_addr), 'h3F82);
        if (!a.rst && a.tag == 4 && a.v == 0 && a.h == 0) check("addr_home", int'(rom_addr), 'h0000);
      end
    end
  end

  task automatic run_frame(input int vact, input int vtot, input int hact, input int htot,
                           input int t, input bit rnd, input int rst_at);
    int c = 0;
    for (int v = 0; v < vtot; v++) begin
      for (int h = 0; h < htot; h++) begin
        @(negedge clk);
        u_vin.vcount = 11'(v);
        u_vin.hcount = 11'(h);
        u_vin.hblnk  = (h >= hact);
        u_vin.vblnk  = (v >= vact);
        u_vin.hsync  = (h >= hact + 1) && (h < hact + 4);
        u_vin.vsync  = (v == vact);
        tag = t;
        if (t == 4) mode = (v == 0 && h < 100) ? BG_ROM : BG_CHECK;
        if (rnd) begin
          if ($urandom_range(15) == 0) mode = bg_mode_t'($urandom_range(3));
          if ($urandom_range(7) == 0) fill_rgb = 12'($urandom);
          scroll_en = 1'($urandom_range(1));
          scroll_dx = 4'($urandom);
          scroll_dy = 4'($urandom);
          home      = ($urandom_range(3) == 0);
        end
        rst_n = (c != rst_at);
        if (rst_at >= 0 && c >= rst_at && c < rst_at + L) tag = 7;
        c++;
      end
    end
  endtask

  initial begin : stim
    rst_n     = 1'b0;
    mode      = BG_ROM;
    fill_rgb  = 12'h000;
    scroll_en = 1'b0;
    scroll_dx = 4'd0;
    scroll_dy = 4'd0;
    home      = 1'b0;
    u_vin.vcount = '0;
    u_vin.hcount = '0;
    u_vin.vsync  = 1'b0;
    u_vin.hsync  = 1'b0;
    u_vin.vblnk  = 1'b0;
    u_vin.hblnk  = 1'b0;
    u_vin.rgb    = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    run_frame(2, 3, 24, 28, 1, 0, -1);
    $display("frame reset_mode0 ox=%0d oy=%0d", m_ox, m_oy);

    scroll_en = 1'b1;
    scroll_dx = 4'd1;
    scroll_dy = 4'd0;
    for (int f = 0; f < 130; f++) begin
      mode     = (f == 128) ? BG_ROM : bg_mode_t'($urandom_range(3));
      fill_rgb = 12'($urandom);
      run_frame(2, 3, 24, 28, (f == 128) ? 2 : 0, 0, -1);
      $display("frame scroll_x %0d ox=%0d oy=%0d", f, m_ox, m_oy);
    end

    mode      = BG_ROM;
    scroll_dx = 4'd0;
    scroll_dy = 4'hF;
    run_frame(2, 3, 24, 28, 0, 0, -1);
    $display("frame scroll_dy ox=%0d oy=%0d", m_ox, m_oy);

    home      = 1'b1;
    scroll_dx = 4'd5;
    scroll_dy = 4'd0;
    run_frame(2, 3, 24, 28, 3, 0, -1);
    $display("frame home ox=%0d oy=%0d", m_ox, m_oy);

    home      = 1'b0;
    scroll_en = 1'b0;
    run_frame(72, 74, 112, 120, 4, 0, -1);
    $display("frame mode_switch ox=%0d oy=%0d", m_ox, m_oy);

    for (int f = 0; f < 10; f++) begin
      run_frame(6, 8, 40, 48, 0, 1, (f == 4) ? int'($urandom_range(40, 200)) : -1);
      $display("frame random %0d ox=%0d oy=%0d", f, m_ox, m_oy);
    end

    home      = 1'b0;
    scroll_en = 1'b0;
    run_frame(2, 3, 24, 28, 0, 0, -1);
    repeat (L + 2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
